// File: rtl/idex_hazard_unit.sv
// idex_hazard_unit: in-flight write scoreboard driving the IF/ID hold, ID/EX bubble, redirect flush and halt drain.
// Optional feature: define IDEX_HAZARD_FORWARD_EN to stall only on load-use and produce registered forwarding selects.
module idex_hazard_unit #(
    parameter int REG_W     = 3,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             D_Valid,
    input  logic [REG_W-1:0] D_Rs,
    input  logic [REG_W-1:0] D_Rt,
    input  logic             D_UsesRs,
    input  logic             D_UsesRt,
    input  logic             D_WriteToReg,
    input  logic [REG_W-1:0] D_WriteReg,
    input  logic             D_MemReadEn,
    input  logic             D_Halt,
    input  logic             X_Redirect,
    output logic             Stall_F,
    output logic             Bubble_D,
    output logic             Flush_F,
    output logic [1:0]       FwdA,
    output logic [1:0]       FwdB,
    output logic             Halted,
    output logic [15:0]      StallCnt
);

    localparam int CNT_W     = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam int STAGE_EX  = 0;
    localparam int STAGE_MEM = 1;
    localparam int STAGE_WB  = 2;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } stateType;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wreg;
        logic             isLoad;
    } sbEntry;

    stateType         state;
    stateType         nextState;
    sbEntry           scoreboard [3];
    sbEntry           decodeEntry;
    logic [CNT_W-1:0] drainCnt;
    logic             drainLoad;
    logic             rsHitEx;
    logic             rsHitMem;
    logic             rtHitEx;
    logic             rtHitMem;
    logic             hazard;

    function automatic logic srcHit(input logic uses, input logic [REG_W-1:0] src, input sbEntry entry);
        return uses && entry.valid && (entry.wreg == src);
    endfunction

    // The WB entry is never compared: the register file writes before it reads.
    assign rsHitEx  = D_Valid && srcHit(D_UsesRs, D_Rs, scoreboard[STAGE_EX]);
    assign rsHitMem = D_Valid && srcHit(D_UsesRs, D_Rs, scoreboard[STAGE_MEM]);
    assign rtHitEx  = D_Valid && srcHit(D_UsesRt, D_Rt, scoreboard[STAGE_EX]);
    assign rtHitMem = D_Valid && srcHit(D_UsesRt, D_Rt, scoreboard[STAGE_MEM]);

`ifdef IDEX_HAZARD_FORWARD_EN
    assign hazard = (rsHitEx || rtHitEx) && scoreboard[STAGE_EX].isLoad;
`else
    assign hazard = rsHitEx || rtHitEx || rsHitMem || rtHitMem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // A halt leaves decode like any other instruction; DRAIN then freezes the front end until it retires.
    always_comb begin
        nextState = state;
        Stall_F   = 1'b0;
        Bubble_D  = 1'b0;
        Flush_F   = 1'b0;
        drainLoad = 1'b0;
        case (state)
            RUN: begin
                if (X_Redirect) begin
                    Flush_F  = 1'b1;
                    Bubble_D = 1'b1;
                end else if (hazard) begin
                    Stall_F  = 1'b1;
                    Bubble_D = 1'b1;
                end else if (D_Valid && D_Halt) begin
                    nextState = DRAIN;
                    drainLoad = 1'b1;
                end
            end
            DRAIN: begin
                Stall_F  = 1'b1;
                Bubble_D = 1'b1;
                if (drainCnt <= CNT_W'(1)) begin
                    nextState = HALTED;
                end
            end
            HALTED: begin
                Stall_F  = 1'b1;
                Bubble_D = 1'b1;
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drainCnt <= '0;
        end else if (drainLoad) begin
            drainCnt <= CNT_W'(DRAIN_CYC);
        end else if (state == DRAIN && drainCnt != '0) begin
            drainCnt <= drainCnt - CNT_W'(1);
        end
    end

    assign Halted = (state == HALTED);

    always_comb begin
        decodeEntry = '0;
        if (!Bubble_D && D_Valid && D_WriteToReg) begin
            decodeEntry.valid  = 1'b1;
            decodeEntry.wreg   = D_WriteReg;
            decodeEntry.isLoad = D_MemReadEn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                scoreboard[i] <= '0;
            end
        end else begin
            scoreboard[STAGE_WB]  <= scoreboard[STAGE_MEM];
            scoreboard[STAGE_MEM] <= scoreboard[STAGE_EX];
            scoreboard[STAGE_EX]  <= decodeEntry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
        end else if (state == RUN && Stall_F && StallCnt != 16'hFFFF) begin
            StallCnt <= StallCnt + 16'd1;
        end
    end

`ifdef IDEX_HAZARD_FORWARD_EN
    function automatic logic [1:0] fwdSel(input logic hitEx, input logic hitMem);
        if (hitEx) begin
            return 2'b01;
        end
        if (hitMem) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // Selects travel with the instruction into EX; a bubble carries no forwarding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FwdA <= 2'b00;
            FwdB <= 2'b00;
        end else if (Bubble_D) begin
            FwdA <= 2'b00;
            FwdB <= 2'b00;
        end else begin
            FwdA <= fwdSel(rsHitEx, rsHitMem);
            FwdB <= fwdSel(rtHitEx, rtHitMem);
        end
    end
`else
    assign FwdA = 2'b00;
    assign FwdB = 2'b00;
`endif

endmodule

// File: tb/tb_idex_hazard_unit.sv
// tb_idex_hazard_unit: directed and randomized checks of idex_hazard_unit against a pipeline-history model.
// Expectations follow IDEX_HAZARD_FORWARD_EN when the bench is built with it defined.
module tb_idex_hazard_unit;

    localparam int REG_W     = 3;
    localparam int DRAIN_CYC = 3;
`ifdef IDEX_HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        dValid = 1'b0;
    logic [2:0]  dRs = '0;
    logic [2:0]  dRt = '0;
    logic        dUsesRs = 1'b0;
    logic        dUsesRt = 1'b0;
    logic        dWriteToReg = 1'b0;
    logic [2:0]  dWriteReg = '0;
    logic        dMemReadEn = 1'b0;
    logic        dHalt = 1'b0;
    logic        xRedirect = 1'b0;
    logic        stallF;
    logic        bubbleD;
    logic        flushF;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        halted;
    logic [15:0] stallCnt;

    idex_hazard_unit #(.REG_W(REG_W), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst_n(rstN),
        .D_Valid(dValid), .D_Rs(dRs), .D_Rt(dRt),
        .D_UsesRs(dUsesRs), .D_UsesRt(dUsesRt),
        .D_WriteToReg(dWriteToReg), .D_WriteReg(dWriteReg),
        .D_MemReadEn(dMemReadEn), .D_Halt(dHalt), .X_Redirect(xRedirect),
        .Stall_F(stallF), .Bubble_D(bubbleD), .Flush_F(flushF),
        .FwdA(fwdA), .FwdB(fwdB), .Halted(halted), .StallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    // One record per instruction that entered EX; the newest is in EX, the one before it in MEM.
    typedef struct {
        bit wr;
        int rd;
        bit ld;
    } producer;

    producer     hist[$];
    int          compared = 0;
    int          mismatched = 0;
    bit          mHalted;
    int          mDrainLeft;
    logic [15:0] mStallCnt;
    logic [1:0]  mFwdA;
    logic [1:0]  mFwdB;
    bit          eStall, eBubble, eFlush;
    bit          rsEx, rsMem, rtEx, rtMem, hazard, running;
    logic        obsStall, obsBubble, obsFlush;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                                 input logic uRs, input logic uRt, input logic wr,
                                 input logic [2:0] wreg, input logic ld, input logic halt,
                                 input logic redir);
        dValid = v; dRs = rs; dRt = rt; dUsesRs = uRs; dUsesRt = uRt;
        dWriteToReg = wr; dWriteReg = wreg; dMemReadEn = ld; dHalt = halt; xRedirect = redir;
    endtask

    task automatic modelReset();
        producer empty;
        empty.wr = 1'b0; empty.rd = 0; empty.ld = 1'b0;
        hist.delete();
        repeat (3) hist.push_back(empty);
        mHalted = 1'b0; mDrainLeft = 0; mStallCnt = '0; mFwdA = '0; mFwdB = '0;
    endtask

    function automatic bit hits(input bit uses, input logic [2:0] src, input producer p);
        return dValid && uses && p.wr && (p.rd == int'(src));
    endfunction

    task automatic modelEval();
        producer ex;
        producer mem;
        ex  = hist[hist.size()-1];
        mem = hist[hist.size()-2];
        rsEx  = hits(dUsesRs, dRs, ex);
        rsMem = hits(dUsesRs, dRs, mem);
        rtEx  = hits(dUsesRt, dRt, ex);
        rtMem = hits(dUsesRt, dRt, mem);
        hazard  = FWD ? ((rsEx || rtEx) && ex.ld) : (rsEx || rtEx || rsMem || rtMem);
        running = !mHalted && (mDrainLeft == 0);
        eFlush  = running && xRedirect;
        eBubble = !running || xRedirect || hazard;
        eStall  = !running || (!xRedirect && hazard);
    endtask

    task automatic modelCommit();
        producer p;
        bit advance;
        advance = !eBubble;
        p.wr = advance && dValid && dWriteToReg;
        p.rd = int'(dWriteReg);
        p.ld = dMemReadEn;
        hist.push_back(p);
        if (hist.size() > 3) hist.delete(0);
        mFwdA = (FWD && advance) ? (rsEx ? 2'b01 : (rsMem ? 2'b10 : 2'b00)) : 2'b00;
        mFwdB = (FWD && advance) ? (rtEx ? 2'b01 : (rtMem ? 2'b10 : 2'b00)) : 2'b00;
        if (running && eStall && mStallCnt != 16'hFFFF) mStallCnt = mStallCnt + 16'd1;
        if (running && !xRedirect && !hazard && dValid && dHalt) begin
            mDrainLeft = DRAIN_CYC;
        end else if (mDrainLeft > 0) begin
            mDrainLeft--;
            if (mDrainLeft == 0) mHalted = 1'b1;
        end
    endtask

    // Called just after a rising edge; compares on the falling edge, then commits the model for the next edge.
    task automatic stepCycle();
        @(negedge clk);
        modelEval();
        obsStall = stallF; obsBubble = bubbleD; obsFlush = flushF;
        checkOutput("Stall_F",  16'(stallF),  16'(eStall));
        checkOutput("Bubble_D", 16'(bubbleD), 16'(eBubble));
        checkOutput("Flush_F",  16'(flushF),  16'(eFlush));
        checkOutput("FwdA",     16'(fwdA),    16'(mFwdA));
        checkOutput("FwdB",     16'(fwdB),    16'(mFwdB));
        checkOutput("Halted",   16'(halted),  16'(mHalted));
        checkOutput("StallCnt", stallCnt,     mStallCnt);
        modelCommit();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) stepCycle();
    endtask

    task automatic issueInstr(input logic [2:0] rs, input logic [2:0] rt, input logic uRs,
                              input logic uRt, input logic wr, input logic [2:0] wreg,
                              input logic ld, input logic halt);
        int guard;
        guard = 0;
        applyStimulus(1, rs, rt, uRs, uRt, wr, wreg, ld, halt, 0);
        stepCycle();
        while (eStall && guard < 8) begin
            stepCycle();
            guard++;
        end
        if (eStall) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL issueTimeout: instruction still held after %0d cycles, required to advance", guard);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " Stall_F"},  16'(stallF),  16'd0);
        checkOutput({tag, " Bubble_D"}, 16'(bubbleD), 16'd0);
        checkOutput({tag, " Flush_F"},  16'(flushF),  16'd0);
        checkOutput({tag, " FwdA"},     16'(fwdA),    16'd0);
        checkOutput({tag, " FwdB"},     16'(fwdB),    16'd0);
        checkOutput({tag, " Halted"},   16'(halted),  16'd0);
        checkOutput({tag, " StallCnt"}, stallCnt,     16'd0);
    endtask

    initial begin
        rstN = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rstN = 1'b1;

        // Independent ADD stream: sources r0/r7 never written.
        for (int i = 1; i <= 6; i++) issueInstr(3'd0, 3'd7, 1, 1, 1, 3'(i), 0, 0);
        checkOutput("stream StallCnt", stallCnt, 16'd0);
        idleCycles(3);

        // ADD r1 ; SUB r4,r1,r1
        issueInstr(3'd0, 3'd7, 1, 1, 1, 3'd1, 0, 0);
        issueInstr(3'd1, 3'd1, 1, 1, 1, 3'd4, 0, 0);
`ifdef IDEX_HAZARD_FORWARD_EN
        checkOutput("raw StallCnt", stallCnt, 16'd0);
        checkOutput("raw FwdA", 16'(fwdA), 16'd1);
        checkOutput("raw FwdB", 16'(fwdB), 16'd1);
`else
        checkOutput("raw StallCnt", stallCnt, 16'd2);
        checkOutput("raw FwdA", 16'(fwdA), 16'd0);
`endif
        idleCycles(3);

        // LD r1 ; ADD r2,r1,r3
        issueInstr(3'd0, 3'd0, 1, 0, 1, 3'd1, 1, 0);
        issueInstr(3'd1, 3'd3, 1, 1, 1, 3'd2, 0, 0);
`ifdef IDEX_HAZARD_FORWARD_EN
        checkOutput("loaduse StallCnt", stallCnt, 16'd1);
        checkOutput("loaduse FwdA", 16'(fwdA), 16'd2);
        checkOutput("loaduse FwdB", 16'(fwdB), 16'd0);
`else
        checkOutput("loaduse StallCnt", stallCnt, 16'd4);
        checkOutput("loaduse FwdA", 16'(fwdA), 16'd0);
`endif
        idleCycles(3);

        // Redirect while decode holds a load-use hazard.
        issueInstr(3'd0, 3'd0, 1, 0, 1, 3'd5, 1, 0);
        applyStimulus(1, 3'd5, 3'd0, 1, 1, 1, 3'd6, 0, 0, 1);
        stepCycle();
        checkOutput("redirect Flush_F",  16'(obsFlush),  16'd1);
        checkOutput("redirect Bubble_D", 16'(obsBubble), 16'd1);
        checkOutput("redirect Stall_F",  16'(obsStall),  16'd0);
`ifdef IDEX_HAZARD_FORWARD_EN
        checkOutput("redirect StallCnt", stallCnt, 16'd1);
`else
        checkOutput("redirect StallCnt", stallCnt, 16'd4);
`endif
        idleCycles(3);

        // Randomized traffic on a narrow register range to provoke hazards and redirects.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 7) != 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 7) == 0);
            stepCycle();
        end
        idleCycles(3);

        // HALT: three drain cycles, redirect ignored, then frozen.
        issueInstr(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1);
        idleCycles(1);
        checkOutput("drain1 Stall_F", 16'(obsStall), 16'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycle();
        checkOutput("drain2 Flush_F",  16'(obsFlush),  16'd0);
        checkOutput("drain2 Bubble_D", 16'(obsBubble), 16'd1);
        checkOutput("drain2 Halted",   16'(halted),    16'd0);
        idleCycles(1);
        checkOutput("drain3 Halted", 16'(halted), 16'd1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1, 1, 1,
                          3'($urandom_range(0, 7)), 0, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            stepCycle();
        end
        checkOutput("halted hold", 16'(halted), 16'd1);

        // Leave HALTED by reset, run again, then reset asynchronously in the middle of DRAIN.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b0;
        #2;
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        issueInstr(3'd0, 3'd7, 1, 1, 1, 3'd2, 0, 0);
        issueInstr(3'd0, 3'd0, 0, 0, 0, 3'd0, 0, 1);
        idleCycles(1);
        rstN = 1'b0;
        #2;
        checkResetOutputs("midDrain");
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int i = 1; i <= 6; i++) issueInstr(3'd7, 3'd0, 1, 1, 1, 3'(i), 0, 0);
        checkOutput("post-reset StallCnt", stallCnt, 16'd0);
        checkOutput("post-reset Halted", 16'(halted), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
